// File: rtl/rom_arb_pkg.sv
// rtl/rom_arb_pkg.sv - shared types and constants for the rom32 read arbiter
//
// Purpose : FSM state encoding, requester count and ROM data width used by
//           rom_arb_picker and rom32_arbiter.
// Ports   : none (package).
package rom_arb_pkg;

  localparam int NUM_REQ    = 2;
  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/rom_arb_picker.sv
// rtl/rom_arb_picker.sv - two-requester winner selection
//
// Purpose : Picks one valid requester. The pointer names the port that wins
//           when both are valid; a lone valid requester always wins.
// Ports   : i_valid [NUM_REQ] - requesters eligible this cycle
//           i_ptr             - preferred port on contention (0 or 1)
//           o_grant [NUM_REQ] - one-hot winner, zero when nobody is valid
module rom_arb_picker
  import rom_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic               i_ptr,
  output logic [NUM_REQ-1:0] o_grant
);

  always_comb begin
    o_grant = '0;
    if (i_ptr) begin
      if (i_valid[1])      o_grant = 2'b10;
      else if (i_valid[0]) o_grant = 2'b01;
    end else begin
      if (i_valid[0])      o_grant = 2'b01;
      else if (i_valid[1]) o_grant = 2'b10;
    end
  end

endmodule

// File: rtl/rom32_arbiter.sv
// rtl/rom32_arbiter.sv - two-port read arbiter in front of a synchronous rom32
//
// Purpose : Serialises reads from two requesters onto one ROM with a
//           1-cycle read latency. One transaction at a time:
//           IDLE (accept) -> READ (ROM data returns) -> RESP (hold until taken).
// Config  : define ROM_ARB_ROUND_ROBIN_EN for round-robin arbitration;
//           otherwise port 0 has fixed priority and no pointer flop exists.
// Ports   : i_clk, i_rst_n       - clock, asynchronous active-low reset
//           i_req_valid[1:0]     - per-port read request
//           o_req_ready[1:0]     - per-port accept (one-hot, IDLE only)
//           i_req_addr0/1        - word address for port 0 / port 1
//           o_rsp_valid[1:0]     - one-hot response valid for the granted port
//           i_rsp_ready[1:0]     - per-port response accept
//           o_rsp_data[31:0]     - response word shared by both ports
//           o_rom_addr           - ROM word address
//           i_rom_data[31:0]     - ROM output, valid the cycle after o_rom_addr
module rom32_arbiter
  import rom_arb_pkg::*;
#(
  parameter  int DEPTH      = 512,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [NUM_REQ-1:0]    i_req_valid,
  output logic [NUM_REQ-1:0]    o_req_ready,
  input  logic [ADDR_WIDTH-1:0] i_req_addr0,
  input  logic [ADDR_WIDTH-1:0] i_req_addr1,
  output logic [NUM_REQ-1:0]    o_rsp_valid,
  input  logic [NUM_REQ-1:0]    i_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_rsp_data,
  output logic [ADDR_WIDTH-1:0] o_rom_addr,
  input  logic [DATA_WIDTH-1:0] i_rom_data
);

  state_e                state_q, state_d;
  logic                  grant_q, grant_d;
  logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  // Holds ready low for the first cycle after reset release.
  logic                  rdy_en_q, rdy_en_d;

  logic [NUM_REQ-1:0]    pick_valid;
  logic [NUM_REQ-1:0]    pick_grant;
  logic                  pick_ptr;
  logic                  hs;
  logic                  win_idx;
  logic [ADDR_WIDTH-1:0] win_addr;

`ifdef ROM_ARB_ROUND_ROBIN_EN
  // Port preferred on the next contention: always the one not granted last.
  logic                  ptr_q, ptr_d;
  assign pick_ptr = ptr_q;
`else
  assign pick_ptr = 1'b0;
`endif

  // Only IDLE offers ready, so the picker sees no requesters elsewhere.
  assign pick_valid = (state_q == IDLE && rdy_en_q) ? i_req_valid : '0;

  rom_arb_picker u_picker (
    .i_valid (pick_valid),
    .i_ptr   (pick_ptr),
    .o_grant (pick_grant)
  );

  assign o_req_ready = pick_grant;
  assign hs          = |pick_grant;
  assign win_idx     = pick_grant[1];
  assign win_addr    = win_idx ? i_req_addr1 : i_req_addr0;

  // The ROM samples the winner's address on the handshake edge itself;
  // otherwise the last issued address is held.
  assign o_rom_addr  = hs ? win_addr : rom_addr_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_data_q;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rom_addr_d  = rom_addr_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = rsp_valid_q;
    rdy_en_d    = 1'b1;
`ifdef ROM_ARB_ROUND_ROBIN_EN
    ptr_d       = ptr_q;
`endif

    case (state_q)
      IDLE: begin
        if (hs) begin
          grant_d    = win_idx;
          rom_addr_d = win_addr;
          state_d    = READ;
`ifdef ROM_ARB_ROUND_ROBIN_EN
          ptr_d      = ~win_idx;
`endif
        end
      end
      READ: begin
        rsp_data_d  = i_rom_data;
        rsp_valid_d = grant_q ? 2'b10 : 2'b01;
        state_d     = RESP;
      end
      RESP: begin
        // Only the granted port's ready can complete the response.
        if (i_rsp_ready[grant_q]) begin
          rsp_valid_d = '0;
          state_d     = IDLE;
        end
      end
      default: begin
        rsp_valid_d = '0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      grant_q     <= 1'b0;
      rom_addr_q  <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= '0;
      rdy_en_q    <= 1'b0;
`ifdef ROM_ARB_ROUND_ROBIN_EN
      ptr_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rom_addr_q  <= rom_addr_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      rdy_en_q    <= rdy_en_d;
`ifdef ROM_ARB_ROUND_ROBIN_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

endmodule

// File: tb/tb_rom32_arbiter.sv
// tb/tb_rom32_arbiter.sv - scoreboard bench for rom32_arbiter
module tb_rom32_arbiter;

  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    req_valid = '0;
  logic [1:0]    req_ready;
  logic [AW-1:0] addr0 = '0;
  logic [AW-1:0] addr1 = '0;
  logic [1:0]    rsp_valid;
  logic [1:0]    rsp_ready = 2'b11;
  logic [31:0]   rsp_data;
  logic [AW-1:0] rom_addr;
  logic [31:0]   rom_data = '0;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    int          port;
    logic [31:0] data;
    int          hs_cyc;
  } exp_t;

  exp_t          sb[$];
  logic [AW-1:0] pend0[$];
  logic [AW-1:0] pend1[$];
  int            glog_port[$];
  int            glog_cyc[$];
  logic          prev_valid = 1'b0;

  always #5 clk = ~clk;

  rom32_arbiter #(.DEPTH(512)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_addr0 (addr0),
    .i_req_addr1 (addr1),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_data  (rsp_data),
    .o_rom_addr  (rom_addr),
    .i_rom_data  (rom_data)
  );

  function automatic logic [31:0] rom_val(input logic [AW-1:0] a);
    case (a)
      9'd0:    rom_val = 32'h0BAD0000;
      9'd1:    rom_val = 32'h11111111;
      9'd2:    rom_val = 32'h22222222;
      9'd5:    rom_val = 32'hDEADBEEF;
      9'd511:  rom_val = 32'hFFFF01FF;
      default: rom_val = 32'hC0DE0000 | {23'd0, a};
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  // Synchronous ROM model: one-cycle read latency.
  always @(posedge clk) rom_data <= rom_val(rom_addr);

  always @(posedge clk) cyc <= cyc + 1;

  // Requester driver: presents the head of each pending queue.
  always @(posedge clk) begin
    #1;
    req_valid[0] = (pend0.size() > 0);
    req_valid[1] = (pend1.size() > 0);
    if (pend0.size() > 0) addr0 = pend0[0];
    if (pend1.size() > 0) addr1 = pend1[0];
  end

  // Handshake observer: a valid&ready seen here completes on the next edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (req_valid[0] && req_ready[0]) begin
        sb.push_back('{port: 0, data: rom_val(addr0), hs_cyc: cyc});
        glog_port.push_back(0);
        glog_cyc.push_back(cyc);
        void'(pend0.pop_front());
      end
      if (req_valid[1] && req_ready[1]) begin
        sb.push_back('{port: 1, data: rom_val(addr1), hs_cyc: cyc});
        glog_port.push_back(1);
        glog_cyc.push_back(cyc);
        void'(pend1.pop_front());
      end
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else if (rsp_valid != 2'b00) begin
      if (sb.size() == 0) begin
        timeout("unexpected_rsp");
      end else begin
        if (!prev_valid) check("rsp_latency", cyc, sb[0].hs_cyc + 2);
        check("rsp_port", rsp_valid, (sb[0].port == 1) ? 2'b10 : 2'b01);
        check("rsp_data", rsp_data, sb[0].data);
        check("ready_in_resp", req_ready, 2'b00);
        if ((rsp_valid & rsp_ready) != 2'b00) void'(sb.pop_front());
      end
      prev_valid = 1'b1;
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((pend0.size() > 0 || pend1.size() > 0 || sb.size() > 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (n >= budget) timeout("drain");
    repeat (2) @(posedge clk);
  endtask

  task automatic wait_rsp_valid(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (rsp_valid == 2'b00 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) timeout(name);
  endtask

  initial begin
    int exp_order[$];

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("reset_req_ready", req_ready, 2'b00);
    check("reset_rsp_valid", rsp_valid, 2'b00);
    check("reset_rsp_data", rsp_data, 32'h0);
    check("reset_rom_addr", rom_addr, '0);
    rst_n = 1'b1;

    // Contention with both ports valid continuously.
    @(posedge clk); #2;
    glog_port.delete(); glog_cyc.delete();
`ifdef ROM_ARB_ROUND_ROBIN_EN
    pend0.push_back(9'd1); pend0.push_back(9'd1);
    pend1.push_back(9'd2); pend1.push_back(9'd2);
    exp_order = '{0, 1, 0, 1};
`else
    pend0.push_back(9'd1); pend0.push_back(9'd1);
    pend0.push_back(9'd1); pend0.push_back(9'd1);
    pend1.push_back(9'd2);
    exp_order = '{0, 0, 0, 0, 1};
`endif
    wait_drain(100);
    check("grant_count", glog_port.size(), exp_order.size());
    for (int i = 0; i < exp_order.size() && i < glog_port.size(); i++)
      check($sformatf("grant_order[%0d]", i), glog_port[i], exp_order[i]);

    // Single read of address 5 on port 0.
    @(posedge clk); #2;
    glog_port.delete(); glog_cyc.delete();
    pend0.push_back(9'd5);
    wait_drain(40);
    check("single_grant_count", glog_port.size(), 1);
    check("single_rom_word", rom_val(9'd5), 32'hDEADBEEF);

    // Port 1 response held off; port 0 ready must be ignored.
    @(posedge clk); #2;
    rsp_ready = 2'b01;
    pend1.push_back(9'd9);
    wait_rsp_valid("hold_wait");
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      check("hold_valid", rsp_valid, 2'b10);
      check("hold_data", rsp_data, 32'hC0DE0009);
      check("hold_req_ready", req_ready, 2'b00);
    end
    @(posedge clk); #1;
    rsp_ready = 2'b11;
    wait_drain(40);

    // Last word then word 0, back to back.
    @(posedge clk); #2;
    glog_port.delete(); glog_cyc.delete();
    pend0.push_back(9'd511);
    pend0.push_back(9'd0);
    wait_drain(40);
    check("b2b_count", glog_port.size(), 2);
    if (glog_cyc.size() == 2) check("b2b_spacing", glog_cyc[1] - glog_cyc[0], 3);

    // Reset pulsed while a response is pending.
    @(posedge clk); #2;
    pend0.push_back(9'd7);
    wait_rsp_valid("rst_wait");
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    sb.delete();
    check("rst_req_ready", req_ready, 2'b00);
    check("rst_rsp_valid", rsp_valid, 2'b00);
    check("rst_rsp_data", rsp_data, 32'h0);
    check("rst_rom_addr", rom_addr, '0);
    pend0.push_back(9'd3);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_first_cycle", req_ready, 2'b00);
    @(negedge clk);
    check("ready_second_cycle", req_ready, 2'b01);
    wait_drain(40);
    check("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rom32_arbiter.md
ROM32_ARBITER -- requirements
Module: rom32_arbiter

Interface
REQ-001 Parameter DEPTH, default 512: ROM word count; SHALL match the attached rom32 instance.
REQ-002 Parameter ADDR_WIDTH, default $clog2(DEPTH): word-address width; local, not overridable.
REQ-003 Port i_clk, input, 1: sole clock, rising edge.
REQ-004 Port i_rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 Port i_req_valid, input, 2: per-requester read request; bit 0 = port 0, bit 1 = port 1.
REQ-006 Port o_req_ready, output, 2: per-requester accept; handshake = valid & ready on a rising edge.
REQ-007 Port i_req_addr0 / i_req_addr1, input, ADDR_WIDTH each: word address for port 0 / port 1.
REQ-008 Port o_rsp_valid, output, 2: one-hot response valid, routed to the granted requester.
REQ-009 Port i_rsp_ready, input, 2: per-requester response accept.
REQ-010 Port o_rsp_data, output, 32: response word, shared by both ports.
REQ-011 Port o_rom_addr, output, ADDR_WIDTH: drives rom32 i_addr.
REQ-012 Port i_rom_data, input, 32: from rom32 o_data; valid the cycle after o_rom_addr is sampled.

Function
REQ-013 SHALL implement a 3-state FSM: IDLE, READ, RESP.
REQ-014 IDLE: o_req_ready SHALL be nonzero only in IDLE, one-hot, set for the winning valid requester; no valid requester -> o_req_ready=0, remain IDLE.
REQ-015 IDLE with a handshake: latch grant index, drive o_rom_addr with the winner's address in the same cycle, next state READ.
REQ-016 READ: capture i_rom_data into the response register, next state RESP; o_rom_addr SHALL hold its last value outside IDLE.
REQ-017 RESP: o_rsp_valid[grant]=1, o_rsp_data stable; on i_rsp_ready[grant]=1, next state IDLE; i_rsp_ready of the non-granted port SHALL be ignored.
REQ-018 Latency: handshake on edge ending cycle N -> o_rsp_valid in cycle N+2; minimum spacing 3 cycles per transaction.
REQ-019 Requests SHALL NOT be dropped; a requester held waiting keeps valid asserted, and address changes before handshake are permitted.
REQ-020 Addresses SHALL be passed unmodified; addresses >= DEPTH are not checked.
REQ-021 Both ports valid in IDLE: winner per REQ-025/026; loser stalls with o_req_ready=0.

Reset
REQ-022 i_rst_n low SHALL immediately force state IDLE, o_req_ready=0, o_rsp_valid=0, o_rsp_data=0, o_rom_addr=0, grant=0, priority pointer=0.
REQ-023 Reset during READ or RESP SHALL discard the transaction without emitting a response.
REQ-024 o_req_ready SHALL be 0 in the first cycle after reset release, and valid from the second cycle.

Configuration
REQ-025 With ROM_ARB_ROUND_ROBIN_EN defined: round-robin arbitration; pointer toggles to the other port after every grant; contention goes to the port not most recently granted.
REQ-026 Without ROM_ARB_ROUND_ROBIN_EN: fixed priority, port 0 always wins contention; no pointer register exists.

Structure
REQ-027 Package rom_arb_pkg SHALL hold the FSM state enum (IDLE, READ, RESP), the constant NUM_REQ=2, and the 32-bit data width constant.
REQ-028 The winner selection SHALL be a sub-module rom_arb_picker (inputs: valid vector, pointer; output: one-hot grant); everything else stays in rom32_arbiter.

Verification
REQ-029 Port 0 reads addr 5 (ROM[5]=0xDEADBEEF), i_rsp_ready=1 -> o_rsp_valid=2'b01 exactly 2 cycles after handshake, data 0xDEADBEEF, FSM back to IDLE.
REQ-030 Both ports valid continuously (addr 1, addr 2), round-robin -> grants alternate 0,1,0,1 with responses ROM[1],ROM[2],ROM[1],ROM[2]; fixed priority -> port 1 never granted.
REQ-031 Port 1 response with i_rsp_ready[1]=0 for 4 cycles -> o_rsp_valid=2'b10 and o_rsp_data held for 4 cycles; o_req_ready=0 throughout; i_rsp_ready[0]=1 has no effect.
REQ-032 i_rst_n pulsed low in RESP -> all outputs 0 asynchronously, no response after release, next request served normally.
REQ-033 Address 511 (last word) and address 0 back-to-back on port 0 -> correct ROM[511] then ROM[0], 3-cycle transaction spacing.
